// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter and sequencer with lock and window checks in front of the single-port data memory
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h10010000,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [1:0]  lock,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] address,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  state_t      r_state, w_next;
  logic        r_win, r_we, r_inr, r_rr_last, r_lock_v, r_lock_own, r_err;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [1:0]  r_ack;
  logic [3:0]  r_cnt;
  logic [1:0]  w_req;
  logic        w_win, w_inr, w_blocked;
  logic [31:0] w_addr;
  always_comb begin
    w_req = r_lock_v ? req & (r_lock_own ? 2'b10 : 2'b01) : req;
    w_win = &w_req ? ~r_rr_last : w_req[1];
    w_addr = w_win ? addr1 : addr0;
    w_inr = {1'b0, w_addr} >= {1'b0, BASE_ADDR} && {1'b0, w_addr} < LIMIT && w_addr[1:0] == 2'b00;
    w_blocked = r_state == IDLE && r_lock_v && req[~r_lock_own];
    w_next = r_state == IDLE ? (|w_req ? ACCESS : IDLE) : r_state == ACCESS ? RESP : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_win <= 1'b0;
      r_we <= 1'b0;
      r_inr <= 1'b0;
      r_rr_last <= 1'b1;
      r_lock_v <= 1'b0;
      r_lock_own <= 1'b0;
      r_err <= 1'b0;
      r_addr <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_ack <= 2'b00;
      r_cnt <= 4'd0;
    end else begin
      r_state <= w_next;
      r_ack <= 2'b00;
      r_cnt <= w_blocked && r_cnt != 4'hf ? r_cnt + 4'd1 : 4'd0;
      if (w_blocked && r_cnt == 4'hf) r_lock_v <= 1'b0;
      if (r_state == IDLE && |w_req) begin
        r_win <= w_win;
        r_addr <= w_addr;
        r_we <= we[w_win];
        r_wdata <= w_win ? wdata1 : wdata0;
        r_inr <= w_inr;
      end
      if (r_state == ACCESS) begin
        r_rdata <= !r_we && r_inr ? readData : 32'd0;
        r_err <= ~r_inr;
        r_ack <= r_win ? 2'b10 : 2'b01;
      end
      if (r_state == RESP) begin
        r_rr_last <= r_win;
        r_lock_v <= lock[r_win];
        r_lock_own <= r_win;
      end
    end
  end
  assign ack = r_ack;
  assign rdata = r_rdata;
  assign err = r_err;
  assign busy = r_state != IDLE;
  assign memRead = rst_n && r_state == ACCESS && !r_we && r_inr;
  assign memWrite = rst_n && r_state == ACCESS && r_we && r_inr;
  assign address = r_addr;
  assign writeData = r_wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural data memory
module tb_dmem_arbiter;
  localparam logic [31:0] BASE = 32'h10010000;
  logic clk = 0, rst_n = 0;
  logic [1:0] req = 0, we = 0, lock = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic [1:0] ack;
  logic [31:0] rdata, address, writeData, readData;
  logic err, busy, memRead, memWrite;
  logic [31:0] mem [0:4095];
  logic bd_we = 0;
  logic [11:0] bd_idx = 0;
  logic [31:0] bd_data = 0;
  typedef struct {logic p; logic [31:0] d; logic e;} exp_t;
  exp_t q[$];
  int n_pass = 0, n_total = 0;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .lock(lock),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy),
    .memRead(memRead), .memWrite(memWrite), .address(address),
    .writeData(writeData), .readData(readData)
  );

  always #5 clk = ~clk;
  assign readData = mem[12'((address - BASE) >> 2)];
  always @(posedge clk) begin
    if (memWrite) mem[12'((address - BASE) >> 2)] <= writeData;
    if (bd_we) mem[bd_idx] <= bd_data;
  end

  function automatic exp_t mk(input logic p, input logic [31:0] d, input logic e);
    exp_t x;
    x.p = p;
    x.d = d;
    x.e = e;
    return x;
  endfunction

  task automatic bd_write(input int i, input logic [31:0] d);
    bd_idx = 12'(i);
    bd_data = d;
    bd_we = 1;
    @(posedge clk);
    #1 bd_we = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    req = 0;
    lock = 0;
    we = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic run_access(input logic p, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d,
                            output logic [1:0] a_o, output logic [31:0] r_o, output logic e_o, output int lat,
                            output logic rd_seen, output logic wr_seen);
    if (p) begin addr1 = a; wdata1 = d; end else begin addr0 = a; wdata0 = d; end
    we[p] = w;
    lock[p] = l;
    req[p] = 1;
    lat = -1;
    rd_seen = 0;
    wr_seen = 0;
    a_o = 0;
    r_o = 0;
    e_o = 0;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      rd_seen |= memRead;
      wr_seen |= memWrite;
      if (ack[p]) begin lat = i; a_o = ack; r_o = rdata; e_o = err; end
    end
    @(posedge clk);
    #1 req[p] = 0;
    lock[p] = 0;
    we[p] = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({ack, rdata, err, busy, memRead, memWrite} !== 0)
      $display("FAIL reset_hold: ack=%b rdata=%h err=%b busy=%b rd=%b wr=%b, want all 0", ack, rdata, err, busy, memRead, memWrite);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    n_total++;
    if ({ack, busy, memRead, memWrite} !== 0) $display("FAIL reset_idle: ack=%b busy=%b, want 0 0", ack, busy);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_simul_stores();
    int t0, t1, lat;
    logic [1:0] got, a_o;
    logic [31:0] r_o;
    logic e_o, rs, ws;
    exp_t e;
    apply_reset();
    q.push_back(mk(0, 32'h0, 0));
    q.push_back(mk(1, 32'h0, 0));
    addr0 = 32'h10010000; wdata0 = 32'h11; addr1 = 32'h10010008; wdata1 = 32'h22;
    we = 2'b11;
    req = 2'b11;
    t0 = -1;
    t1 = -1;
    for (int i = 0; i < 20 && (t0 < 0 || t1 < 0); i++) begin
      @(negedge clk);
      got = ack;
      if (|got) begin
        n_total++;
        if (q.size() == 0) $display("FAIL stores_unexpected_ack: ack=%b, want none", got);
        else begin
          e = q.pop_front();
          if (got !== (e.p ? 2'b10 : 2'b01) || rdata !== e.d || err !== e.e)
            $display("FAIL stores_ack: ack=%b rdata=%h err=%b, want ack=%b rdata=%h err=%b", got, rdata, err, e.p ? 2'b10 : 2'b01, e.d, e.e);
          else n_pass++;
        end
        if (got[0]) t0 = i;
        if (got[1]) t1 = i;
      end
      @(posedge clk);
      #1 req = req & ~got;
    end
    req = 0;
    we = 0;
    n_total++;
    if (t0 !== 2) $display("FAIL stores_p0_latency: got %0d, want 2", t0); else n_pass++;
    n_total++;
    if (t1 - t0 !== 3) $display("FAIL stores_p1_gap: got %0d, want 3", t1 - t0); else n_pass++;
    q.push_back(mk(0, 32'h11, 0));
    run_access(0, 0, 0, 32'h10010000, 0, a_o, r_o, e_o, lat, rs, ws);
    e = q.pop_front();
    n_total++;
    if (a_o !== 2'b01 || r_o !== e.d || e_o !== e.e) $display("FAIL readback_w0: ack=%b rdata=%h err=%b, want 01 %h %b", a_o, r_o, e_o, e.d, e.e);
    else n_pass++;
    q.push_back(mk(1, 32'h22, 0));
    run_access(1, 0, 0, 32'h10010008, 0, a_o, r_o, e_o, lat, rs, ws);
    e = q.pop_front();
    n_total++;
    if (a_o !== 2'b10 || r_o !== e.d || e_o !== e.e) $display("FAIL readback_w2: ack=%b rdata=%h err=%b, want 10 %h %b", a_o, r_o, e_o, e.d, e.e);
    else n_pass++;
  endtask

  task automatic test_single_load();
    exp_t e;
    q.push_back(mk(0, 32'hDEADBEEF, 0));
    addr0 = 32'h10010004;
    we[0] = 0;
    req[0] = 1;
    @(negedge clk);
    n_total++;
    if (memRead !== 0 || ack !== 0) $display("FAIL load_cycle_n: memRead=%b ack=%b, want 0 00", memRead, ack); else n_pass++;
    @(negedge clk);
    n_total++;
    if (memRead !== 1 || address !== 32'h10010004) $display("FAIL load_cycle_n1: memRead=%b address=%h, want 1 10010004", memRead, address);
    else n_pass++;
    @(negedge clk);
    e = q.pop_front();
    n_total++;
    if (ack !== 2'b01 || rdata !== e.d || err !== e.e || memRead !== 0)
      $display("FAIL load_ack: ack=%b rdata=%h err=%b memRead=%b, want 01 %h %b 0", ack, rdata, err, memRead, e.d, e.e);
    else n_pass++;
    @(posedge clk);
    #1 req[0] = 0;
  endtask

  task automatic test_alternate();
    int n;
    exp_t e;
    apply_reset();
    for (int k = 0; k < 4; k++) q.push_back(k % 2 == 0 ? mk(0, 32'hA5, 0) : mk(1, 32'hB6, 0));
    addr0 = 32'h10010014;
    addr1 = 32'h10010018;
    we = 0;
    req = 2'b11;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (|ack) begin
        n++;
        n_total++;
        if (q.size() == 0) $display("FAIL alt_unexpected_ack: ack=%b, want none", ack);
        else begin
          e = q.pop_front();
          if (ack !== (e.p ? 2'b10 : 2'b01) || rdata !== e.d)
            $display("FAIL alt_grant_%0d: ack=%b rdata=%h, want ack=%b rdata=%h", n, ack, rdata, e.p ? 2'b10 : 2'b01, e.d);
          else n_pass++;
        end
      end
    end
    @(posedge clk);
    #1 req = 0;
    n_total++;
    if (n !== 4) $display("FAIL alt_count: got %0d acks, want 4", n); else n_pass++;
  endtask

  task automatic test_errors();
    logic [1:0] a_o;
    logic [31:0] r_o;
    logic e_o, rs, ws;
    int lat;
    exp_t e;
    q.push_back(mk(0, 32'h0, 1));
    run_access(0, 0, 0, 32'h1000FFFC, 0, a_o, r_o, e_o, lat, rs, ws);
    e = q.pop_front();
    n_total++;
    if (a_o !== 2'b01 || r_o !== e.d || e_o !== e.e || rs !== 0)
      $display("FAIL err_below: ack=%b rdata=%h err=%b memRead_seen=%b, want 01 0 1 0", a_o, r_o, e_o, rs);
    else n_pass++;
    q.push_back(mk(1, 32'h0, 1));
    run_access(1, 1, 0, 32'h10014000, 32'h99, a_o, r_o, e_o, lat, rs, ws);
    e = q.pop_front();
    n_total++;
    if (a_o !== 2'b10 || r_o !== e.d || e_o !== e.e || ws !== 0)
      $display("FAIL err_above: ack=%b rdata=%h err=%b memWrite_seen=%b, want 10 0 1 0", a_o, r_o, e_o, ws);
    else n_pass++;
    q.push_back(mk(0, 32'h0, 1));
    run_access(0, 1, 0, 32'h10010002, 32'h33, a_o, r_o, e_o, lat, rs, ws);
    e = q.pop_front();
    n_total++;
    if (a_o !== 2'b01 || r_o !== e.d || e_o !== e.e || ws !== 0)
      $display("FAIL err_misaligned: ack=%b rdata=%h err=%b memWrite_seen=%b, want 01 0 1 0", a_o, r_o, e_o, ws);
    else n_pass++;
  endtask

  task automatic test_lock();
    logic [1:0] got, a_o;
    logic [31:0] r_o;
    logic e_o, rs, ws;
    int lat, n;
    exp_t e;
    q.push_back(mk(0, 32'h11, 0));
    run_access(0, 0, 0, 32'h10010000, 0, a_o, r_o, e_o, lat, rs, ws);
    e = q.pop_front();
    n_total++;
    if (a_o !== 2'b01 || r_o !== e.d) $display("FAIL lock_prep: ack=%b rdata=%h, want 01 %h", a_o, r_o, e.d); else n_pass++;
    q.push_back(mk(1, 32'h22, 0));
    q.push_back(mk(1, 32'h0, 0));
    q.push_back(mk(0, 32'hA5, 0));
    addr1 = 32'h10010008; we[1] = 0; lock[1] = 1;
    addr0 = 32'h10010014; we[0] = 0;
    req = 2'b11;
    n = 0;
    for (int i = 0; i < 30 && n < 3; i++) begin
      @(negedge clk);
      got = ack;
      if (|got) begin
        n++;
        n_total++;
        if (q.size() == 0) $display("FAIL lock_unexpected_ack: ack=%b, want none", got);
        else begin
          e = q.pop_front();
          if (got !== (e.p ? 2'b10 : 2'b01) || rdata !== e.d)
            $display("FAIL lock_order_%0d: ack=%b rdata=%h, want ack=%b rdata=%h", n, got, rdata, e.p ? 2'b10 : 2'b01, e.d);
          else n_pass++;
        end
      end
      @(posedge clk);
      #1;
      if (got[1] && n == 1) begin addr1 = 32'h1001001C; wdata1 = 32'h77; we[1] = 1; lock[1] = 0; end
      else if (got[1]) req[1] = 0;
      if (got[0]) req[0] = 0;
    end
    req = 0;
    we = 0;
    lock = 0;
    n_total++;
    if (n !== 3) $display("FAIL lock_count: got %0d acks, want 3", n); else n_pass++;
    n_total++;
    if (mem[7] !== 32'h77) $display("FAIL lock_store_data: word7=%h, want 00000077", mem[7]); else n_pass++;
  endtask

  task automatic test_starvation();
    logic [1:0] a_o;
    logic [31:0] r_o;
    logic e_o, rs, ws;
    int lat;
    exp_t e;
    q.push_back(mk(1, 32'h22, 0));
    run_access(1, 0, 1, 32'h10010008, 0, a_o, r_o, e_o, lat, rs, ws);
    e = q.pop_front();
    n_total++;
    if (a_o !== 2'b10 || r_o !== e.d) $display("FAIL starve_lock_load: ack=%b rdata=%h, want 10 %h", a_o, r_o, e.d); else n_pass++;
    q.push_back(mk(0, 32'hA5, 0));
    addr0 = 32'h10010014;
    we[0] = 0;
    req[0] = 1;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (|ack) begin
        lat = i;
        e = q.pop_front();
        n_total++;
        if (ack !== 2'b01 || rdata !== e.d) $display("FAIL starve_ack: ack=%b rdata=%h, want 01 %h", ack, rdata, e.d); else n_pass++;
        break;
      end
    end
    @(posedge clk);
    #1 req = 0;
    n_total++;
    if (lat !== 18) $display("FAIL starve_latency: got %0d, want 18", lat); else n_pass++;
  endtask

  task automatic test_reset_during_access();
    addr0 = 32'h10010010;
    wdata0 = 32'h55;
    we[0] = 1;
    req[0] = 1;
    @(posedge clk);
    #1 rst_n = 0;
    @(negedge clk);
    n_total++;
    if (memWrite !== 0 || memRead !== 0) $display("FAIL rst_access_gate: memWrite=%b memRead=%b, want 0 0", memWrite, memRead); else n_pass++;
    @(posedge clk);
    #1 req = 0;
    we = 0;
    @(negedge clk);
    n_total++;
    if ({ack, rdata, err, busy, memRead, memWrite, address, writeData} !== 0)
      $display("FAIL rst_access_outputs: ack=%b rdata=%h err=%b busy=%b addr=%h wdata=%h, want all 0", ack, rdata, err, busy, address, writeData);
    else n_pass++;
    n_total++;
    if (mem[4] !== 32'h44444444) $display("FAIL rst_access_word4: got %h, want 44444444", mem[4]); else n_pass++;
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    bd_write(1, 32'hDEADBEEF);
    bd_write(4, 32'h44444444);
    bd_write(5, 32'hA5);
    bd_write(6, 32'hB6);
    test_reset();
    test_simul_stores();
    test_single_load();
    test_alternate();
    test_errors();
    test_lock();
    test_starvation();
    test_reset_during_access();
    n_total++;
    if (q.size() !== 0) $display("FAIL scoreboard_drain: %0d left, want 0", q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
